// File: rtl/fetch_prefetch_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                       |
// | Purpose  : Shared constants, FIFO entry type and issue-state encoding.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fetch_pkg;

    localparam int INSTR_W         = 32;
    localparam int BYTES_PER_INSTR = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_prefetch_buffer_if                                        |
// | Purpose  : Instruction-memory, redirect and datapath handshake bundle.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fetch_prefetch_buffer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 5
);
    logic               imem_re;
    logic [ADDR_W-1:0]  imem_addr;
    logic [7:0]         imem_rdata;
    logic               redirect_valid;
    logic [INSTR_W-1:0] redirect_pc;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_data;
    logic [INSTR_W-1:0] inst_pc;

    modport master (
        output imem_re, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_re, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_prefetch_buffer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_fifo                                                      |
// | Purpose  : Synchronous FIFO of {pc, instr} entries; flush beats push.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_push_entry,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_push_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_prefetch_buffer                                           |
// | Purpose  : Byte-serial instruction fetch, big-endian word assembly and     |
// |            prefetch FIFO. Define FETCH_PERF_EN for flush/stall counters.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_prefetch_buffer_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]             perf_flush_cnt,
    output logic [15:0]             perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(BYTES_PER_INSTR);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(BYTES_PER_INSTR - 1);

    issue_state_t         r_state;
    issue_state_t         w_state_nxt;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [IDX_W-1:0]     r_byte_idx;
    logic                 r_pending;
    logic                 r_inflight;
    logic [IDX_W-1:0]     r_ret_idx;
    logic [INSTR_W-9:0]   r_asm;
    logic                 w_can_start;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [ADDR_W-1:0]    w_word_pc;
    fetch_entry_t         w_push_entry;
    fetch_entry_t         w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_unused;

    assign w_unused    = ^{bus.redirect_pc[INSTR_W-1:ADDR_W], bus.redirect_pc[1:0]};
    // Including the word still being assembled guarantees a free slot at its push
    assign w_can_start = (32'(w_count) + 32'(r_pending)) < 32'(DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ISSUE: begin
                if (r_byte_idx != '0 || w_can_start) w_issue = 1'b1;
                else                                 w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_can_start) w_state_nxt = ISSUE;
            end
            default: w_state_nxt = ISSUE;
        endcase
        if (bus.redirect_valid) w_state_nxt = ISSUE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ISSUE;
            r_fetch_pc <= '0;
            r_byte_idx <= '0;
            r_pending  <= 1'b0;
            r_inflight <= 1'b0;
            r_ret_idx  <= '0;
            r_asm      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Clearing the tag on redirect drops the byte returning next cycle
            r_inflight <= w_issue && !bus.redirect_valid;
            r_ret_idx  <= r_byte_idx;
            if (bus.redirect_valid) begin
                r_fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
                r_byte_idx <= '0;
                r_pending  <= 1'b0;
                r_asm      <= '0;
            end else begin
                if (r_inflight) r_asm <= {r_asm[INSTR_W-17:0], bus.imem_rdata};
                if (w_issue) begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                    if (r_byte_idx == c_last_idx)
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(BYTES_PER_INSTR);
                end
                if (w_issue && r_byte_idx == '0) r_pending <= 1'b1;
                else if (w_push)                 r_pending <= 1'b0;
            end
        end
    end

    // fetch_pc has already stepped past the word whose last byte is returning
    assign w_word_pc = r_fetch_pc - ADDR_W'(BYTES_PER_INSTR);
    assign w_push    = r_inflight && (r_ret_idx == c_last_idx);
    assign w_pop     = (w_count != '0) && bus.inst_ready;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = INSTR_W'(w_word_pc);
        w_push_entry.instr = {r_asm, bus.imem_rdata};
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (bus.redirect_valid),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign bus.imem_re    = w_issue && !rst;
    assign bus.imem_addr  = r_fetch_pc + ADDR_W'(r_byte_idx);
    assign bus.inst_valid = !rst && (w_count != '0);
    assign bus.inst_data  = rst ? '0 : w_head.instr;
    assign bus.inst_pc    = rst ? '0 : w_head.pc;

`ifdef FETCH_PERF_EN
    logic [15:0] r_flush_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.redirect_valid && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_state == IDLE && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign perf_flush_cnt = r_flush_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle datapath.
- Reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit words (first byte lands in [31:23+1], i.e. [31:24]).
- Queues each {pc, instruction} pair in a small FIFO and hands it to the datapath over a valid/ready handshake.
- Supports a redirect (branch/jump target) that flushes all buffered and in-flight fetch state.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- ADDR_W, 5: byte address width of instruction memory (32 bytes); PC wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_re  out  1  byte read strobe.
- imem_addr  out  ADDR_W  byte address of the read.
- imem_rdata  in  8  read data, valid the cycle after imem_re.
- redirect_valid  in  1  load a new fetch PC.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0), bits above ADDR_W ignored.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  datapath accepts the head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC, zero-extended from ADDR_W.

Behaviour:
- Reset: rst is sampled on the clk rising edge. It clears fetch_pc=0, the FIFO (count=0, pointers=0), the byte index, the in-flight tag and the assembly register. Outputs during reset: imem_re=0, inst_valid=0, inst_data=0, inst_pc=0. Reset takes priority over everything, including mid-word assembly.
- Issue FSM, states IDLE and ISSUE:
  - ISSUE drives imem_re=1 with imem_addr=fetch_pc+byte_idx, where byte_idx runs 0..3.
  - After byte_idx=3, fetch_pc advances by 4 (wrapping) and byte_idx returns to 0.
  - A new word (byte_idx=0) starts only if count + pending < DEPTH. pending=1 while a word has issued bytes but has not yet been pushed. If the condition fails, the FSM moves to IDLE with imem_re=0.
  - IDLE returns to ISSUE on the first cycle the condition holds.
- Receive path:
  - Each returned byte is shifted into the assembly register; byte 0 lands in [31:24].
  - When byte 3 returns, {word_pc, word} is pushed. pending clears in the same cycle.
- Timing: the first cycle after reset release is cycle 0.
  - Bytes are issued in cycles 0..3 and the push happens at the end of cycle 4.
  - inst_valid=1 in cycle 5.
  - Steady-state throughput is 1 word per 4 cycles. Byte issue of the next word overlaps the return of the last byte of the previous word.
- Handshake:
  - A pop happens when inst_valid && inst_ready.
  - inst_data and inst_pc are stable while inst_valid=1 and ready=0.
  - A simultaneous push and pop leaves count unchanged.
  - Full FIFO: no push can occur, guaranteed by the start condition. Empty FIFO: inst_valid=0 and inst_ready is ignored.
- Redirect (redirect_valid=1 in cycle r):
  - Any pop handshake in cycle r completes normally.
  - At the end of cycle r: the FIFO is flushed, the partial word is discarded, byte_idx=0, fetch_pc=redirect_pc[ADDR_W-1:2]<<2.
  - Any byte returning in cycle r+1 is discarded via the in-flight tag.
  - Issue of the new target starts in cycle r+1. inst_valid first rises in cycle r+6.
  - A redirect in consecutive cycles: the last redirect wins.
- Width and wrap: fetch_pc+byte_idx wraps modulo 2^ADDR_W. count width is clog2(DEPTH+1).

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, two output ports are added:
  - perf_flush_cnt (16): increments on each redirect_valid cycle.
  - perf_stall_cnt (16): increments each cycle the FSM is in IDLE outside reset.
  - Both saturate at 16'hFFFF and are cleared by rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W=32 and BYTES_PER_INSTR=4 constants.
  - The fetch_entry_t struct {pc, instr}.
  - The issue-state enum {IDLE, ISSUE}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush ports, count output, and flush priority over push.

Test Plan:
- Reset-release fetch: mem[0..3]=8C,22,00,04 and inst_ready=1 -> cycle 5 shows inst_valid=1, inst_data=32'h8C220004, inst_pc=0.
- Backpressure: hold inst_ready=0 -> after 4 words imem_re=0, the FSM stays in IDLE, and the head stays at pc 0. Raise ready -> words at pc 0,4,8,12 in order, then fetch resumes at 16.
- Wrap-around: redirect_pc=28 -> words at pc 28 then 0, matching the contents of mem[28..31] and mem[0..3].
- Redirect mid-word: redirect_pc=32'h13 asserted while byte_idx=2 -> no partial word appears, the next inst_pc is 16, and the byte returning in r+1 is dropped.
- Redirect with simultaneous pop: a handshake in cycle r is consumed once, the FIFO is empty at r+1, and inst_valid=0 until r+6.
- Reset mid-operation: rst pulsed with 3 words queued -> inst_valid=0 the next cycle, and fetch restarts at pc 0. With FETCH_PERF_EN defined, both counters read 0 after reset.
